// File: rtl/sim_test_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sim_test_ctrl
// Purpose  : Test-control block for the minimal SOPC simulation environment.
//            Produces the core reset (2-flop synchronised release plus a
//            programmable hold), watches the core write bus for tohost
//            pass/fail writes and console characters, and runs a cycle
//            watchdog so the bench can stop on a real result.
// Ports    : clk_i           system clock
//            rst_ni          asynchronous active-low reset
//            core_rst_o      active-high core reset (async assert, sync release)
//            wr_en_i         core data-write strobe
//            wr_addr_i       write address  [ADDR_W]
//            wr_data_i       write data     [DATA_W]
//            halt_o/done_o   high in DONE
//            pass_o          1 = test passed (valid when done_o)
//            timeout_o       1 = watchdog expired (valid when done_o)
//            fail_code_o     wr_data>>1 of the failing tohost write [DATA_W-1]
//            cycle_count_o   RUN cycles, saturating, frozen in DONE [CNT_W]
//            con_valid_o     one-cycle pulse per accepted console write
//            con_char_o      last console character
// Revision : 1.0 - initial release
// ============================================================================
module sim_test_ctrl #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                CNT_W        = 32,
  parameter int                RST_HOLD     = 8,
  parameter int                MAX_CYCLES   = 1000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(32'h0000_1000),
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR = ADDR_W'(32'h0000_1004)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              core_rst_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              halt_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [DATA_W-2:0] fail_code_o,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic              con_valid_o,
  output logic [7:0]        con_char_o
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0]       c_hold    = 8'(RST_HOLD);
  localparam bit               c_wd_en   = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] c_wd_last = CNT_W'(MAX_CYCLES - 1);

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic [7:0]          hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic [DATA_W-2:0]   fail_code_q, fail_code_d;
  logic                con_valid_q, con_valid_d;
  logic [7:0]          con_char_q, con_char_d;

  logic                w_tohost_hit;
  logic                w_con_hit;
  logic                w_wd_hit;
  logic [7:0]          w_hold_next;

  // Only odd data on the tohost word ends the test; even values are ignored.
  assign w_tohost_hit = wr_en_i && (wr_addr_i == TOHOST_ADDR) && wr_data_i[0];
  assign w_con_hit    = wr_en_i && (wr_addr_i == CONSOLE_ADDR);
  assign w_wd_hit     = c_wd_en && (cycle_count_q == c_wd_last);
  assign w_hold_next  = hold_cnt_q + 8'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_HOLD;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      hold_cnt_q    <= 8'd0;
      cycle_count_q <= '0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_code_q   <= '0;
      con_valid_q   <= 1'b0;
      con_char_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= 1'b1;
      sync2_q       <= sync1_q;
      hold_cnt_q    <= hold_cnt_d;
      cycle_count_q <= cycle_count_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      fail_code_q   <= fail_code_d;
      con_valid_q   <= con_valid_d;
      con_char_q    <= con_char_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    cycle_count_d = cycle_count_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    fail_code_d   = fail_code_q;
    con_valid_d   = 1'b0;
    con_char_d    = con_char_q;

    unique case (state_q)
      ST_HOLD: begin
        // Hold time only starts once the synchronised release is seen, so
        // release latency is exactly 2 + RST_HOLD edges.
        if (sync2_q) begin
          hold_cnt_d = w_hold_next;
          if (w_hold_next == c_hold) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end

        // A tohost write in the expiry cycle takes priority over the watchdog.
        if (w_tohost_hit) begin
          state_d   = ST_DONE;
          timeout_d = 1'b0;
          if (wr_data_i == DATA_W'(1)) begin
            pass_d      = 1'b1;
            fail_code_d = '0;
          end else begin
            pass_d      = 1'b0;
            fail_code_d = wr_data_i[DATA_W-1:1];
          end
        end else if (w_wd_hit) begin
          state_d     = ST_DONE;
          timeout_d   = 1'b1;
          pass_d      = 1'b0;
          fail_code_d = '0;
        end

        if (w_con_hit) begin
          con_valid_d = 1'b1;
          con_char_d  = wr_data_i[7:0];
        end
      end

      ST_DONE: begin
        // Terminal: results held until reset.
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  assign core_rst_o    = (state_q == ST_HOLD);
  assign done_o        = (state_q == ST_DONE);
  assign halt_o        = (state_q == ST_DONE);
  assign pass_o        = pass_q;
  assign timeout_o     = timeout_q;
  assign fail_code_o   = fail_code_q;
  assign cycle_count_o = cycle_count_q;
  assign con_valid_o   = con_valid_q;
  assign con_char_o    = con_char_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_test_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sim_test_ctrl
// Purpose  : Self-checking bench for sim_test_ctrl. A driver issues randomised
//            bus traffic and pushes expected results; a monitor pops and
//            compares whenever the DUT shows done or a console pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_test_ctrl;

  localparam int          ADDR_W     = 32;
  localparam int          DATA_W     = 32;
  localparam int          CNT_W      = 32;
  localparam int          RST_HOLD   = 8;
  localparam int          MAX_CYCLES = 1000;
  localparam logic [31:0] TOHOST     = 32'h0000_1000;
  localparam logic [31:0] CONSOLE    = 32'h0000_1004;

  logic              clk;
  logic              rst_n;
  logic              core_rst_o;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              halt_o, done_o, pass_o, timeout_o;
  logic [DATA_W-2:0] fail_code_o;
  logic [CNT_W-1:0]  cycle_count_o;
  logic              con_valid_o;
  logic [7:0]        con_char_o;

  sim_test_ctrl #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .CNT_W       (CNT_W),
    .RST_HOLD    (RST_HOLD),
    .MAX_CYCLES  (MAX_CYCLES),
    .TOHOST_ADDR (TOHOST),
    .CONSOLE_ADDR(CONSOLE)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .core_rst_o   (core_rst_o),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .halt_o       (halt_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .timeout_o    (timeout_o),
    .fail_code_o  (fail_code_o),
    .cycle_count_o(cycle_count_o),
    .con_valid_o  (con_valid_o),
    .con_char_o   (con_char_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic              p;
    logic              t;
    logic [DATA_W-2:0] fc;
    logic [CNT_W-1:0]  cnt;
  } res_t;

  typedef struct packed {
    logic [7:0]  ch;
    logic [31:0] due;
  } con_t;

  res_t        res_q[$];
  con_t        con_q[$];
  int unsigned edge_cnt = 0;
  int unsigned k = 0;   // model: current RUN cycle index

  always @(posedge clk) edge_cnt++;

  // ---------------------------------------------------------------- monitor
  res_t cur;
  bit   cur_ok  = 1'b0;
  bit   in_done = 1'b0;

  always @(negedge clk) begin
    if (done_o) begin
      if (!in_done) begin
        in_done = 1'b1;
        chk("done_expected", 64'(res_q.size() != 0), 64'd1);
        if (res_q.size() != 0) begin
          cur    = res_q.pop_front();
          cur_ok = 1'b1;
        end else begin
          cur_ok = 1'b0;
        end
      end
      if (cur_ok) begin
        chk("pass",        64'(pass_o),        64'(cur.p));
        chk("timeout",     64'(timeout_o),     64'(cur.t));
        chk("fail_code",   64'(fail_code_o),   64'(cur.fc));
        chk("cycle_frozen",64'(cycle_count_o), 64'(cur.cnt));
        chk("halt",        64'(halt_o),        64'd1);
        chk("core_rst_done", 64'(core_rst_o),  64'd0);
      end
    end else begin
      in_done = 1'b0;
    end

    if (con_q.size() != 0 && con_q[0].due == edge_cnt) begin
      con_t c;
      c = con_q.pop_front();
      chk("con_valid", 64'(con_valid_o), 64'd1);
      chk("con_char",  64'(con_char_o),  64'(c.ch));
    end else if (con_valid_o) begin
      chk("spurious_con_valid", 64'(con_valid_o), 64'd0);
    end
  end

  // ----------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] a, input logic [31:0] d);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rst_core_rst",  64'(core_rst_o),    64'd1);
    chk("rst_halt",      64'(halt_o),        64'd0);
    chk("rst_done",      64'(done_o),        64'd0);
    chk("rst_pass",      64'(pass_o),        64'd0);
    chk("rst_timeout",   64'(timeout_o),     64'd0);
    chk("rst_fail_code", 64'(fail_code_o),   64'd0);
    chk("rst_cycle_cnt", 64'(cycle_count_o), 64'd0);
    chk("rst_con_valid", 64'(con_valid_o),   64'd0);
    chk("rst_con_char",  64'(con_char_o),    64'd0);
  endtask

  // Count rising edges from the rst release until core_rst drops.
  task automatic wait_release();
    int e = 0;
    do begin
      @(posedge clk);
      e++;
      #1;
    end while (core_rst_o && e < 40);
    chk("release_edges", 64'(e), 64'(2 + RST_HOLD));
    chk("first_run_count", 64'(cycle_count_o), 64'd0);
    k = 0;
  endtask

  task automatic con_write(input logic [7:0] ch);
    chk("cycle_count", 64'(cycle_count_o), 64'(k));
    drive(1'b1, CONSOLE, {24'h0, ch});
    con_q.push_back('{ch: ch, due: edge_cnt + 1});
    tick();
    k++;
    idle();
  endtask

  // Random traffic that must never end the test.
  task automatic noise(input bit allow_con);
    int unsigned sel;
    logic [31:0] a, d;
    sel = $urandom_range(0, allow_con ? 3 : 2);
    d   = $urandom;
    case (sel)
      0: drive(1'b0, ($urandom_range(0, 1) != 0) ? TOHOST : CONSOLE, d | 32'd1);
      1: begin
        if ($urandom_range(0, 1) != 0) a = TOHOST ^ (32'd1 << $urandom_range(12, 31));
        else begin
          a = $urandom;
          if (a == TOHOST || a == CONSOLE) a = a ^ 32'h8000_0000;
        end
        drive(1'b1, a, d | 32'd1);
      end
      2: drive(1'b1, TOHOST, d & ~32'd1);
      default: begin
        drive(1'b1, CONSOLE, d);
        con_q.push_back('{ch: d[7:0], due: edge_cnt + 1});
      end
    endcase
  endtask

  task automatic run_to(input int unsigned target, input bit allow_con);
    while (k < target) begin
      chk("cycle_count", 64'(cycle_count_o), 64'(k));
      noise(allow_con);
      tick();
      k++;
    end
    idle();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 4) begin
      tick();
      n++;
    end
    chk("done_within_bound", 64'(done_o), 64'd1);
  endtask

  task automatic term_write(input logic [31:0] d);
    res_t r;
    chk("cycle_count", 64'(cycle_count_o), 64'(k));
    r.p   = (d == 32'd1);
    r.t   = 1'b0;
    r.fc  = r.p ? '0 : d[31:1];
    r.cnt = CNT_W'(k + 1);
    res_q.push_back(r);
    drive(1'b1, TOHOST, d);
    tick();
    idle();
    wait_done();
  endtask

  task automatic watchdog_expire();
    res_t r;
    chk("cycle_count", 64'(cycle_count_o), 64'(k));
    r.p   = 1'b0;
    r.t   = 1'b1;
    r.fc  = '0;
    r.cnt = CNT_W'(MAX_CYCLES);
    res_q.push_back(r);
    idle();
    tick();
    wait_done();
  endtask

  // Writes in DONE: no console pulse, results stay put (monitor checks).
  task automatic done_linger();
    drive(1'b1, CONSOLE, 32'h58);
    tick();
    drive(1'b1, TOHOST, 32'h0000_0005);
    tick();
    idle();
    tick();
    tick();
  endtask

  // Called at #1 after an edge: reset must act without a clock edge.
  task automatic reset_cycle();
    rst_n = 1'b0;
    #2;
    check_reset_vals();
    @(negedge clk);
    @(negedge clk);
    #5;
    rst_n = 1'b1;
    wait_release();
  endtask

  function automatic logic [31:0] rand_fail();
    logic [31:0] d;
    d = $urandom | 32'd1;
    if (d == 32'd1) d = 32'd3;
    return d;
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    #100;
    check_reset_vals();
    #95;
    rst_n = 1'b1;           // released at 195 ns
    wait_release();

    // Pass, with back-to-back console characters
    run_to(10, 1'b1);
    con_write(8'h4F);
    con_write(8'h4B);
    run_to(50, 1'b1);
    term_write(32'd1);
    done_linger();

    // Ignored even write, then fail code 3, then a random fail code
    reset_cycle();
    run_to(20, 1'b1);
    chk("cycle_count", 64'(cycle_count_o), 64'(k));
    drive(1'b1, TOHOST, 32'd0);
    tick();
    k++;
    idle();
    chk("even_tohost_ignored", 64'(done_o), 64'd0);
    term_write(32'h0000_0007);
    done_linger();

    reset_cycle();
    run_to(30 + $urandom_range(0, 40), 1'b1);
    term_write(rand_fail());
    done_linger();

    // Watchdog expiry
    reset_cycle();
    run_to(MAX_CYCLES - 1, 1'b1);
    watchdog_expire();
    done_linger();

    // tohost pass in the expiry cycle wins
    reset_cycle();
    run_to(MAX_CYCLES - 1, 1'b1);
    term_write(32'd1);
    done_linger();

    // Reset mid-run, then the sequence repeats
    reset_cycle();
    run_to(100, 1'b1);
    con_write(8'h5A);
    run_to(290, 1'b1);
    run_to(300, 1'b0);
    reset_cycle();
    run_to(5, 1'b1);
    term_write(rand_fail());
    done_linger();

    chk("con_queue_drained", 64'(con_q.size()), 64'd0);
    chk("res_queue_drained", 64'(res_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
